// File: rtl/sram_seq_ctrl.sv
// Burst sequencer for the input SRAM (5-bit address) and the Wq SRAM (10-bit address).
// Accepts write/read burst commands and streams data between the SRAMs and the host.
module sram_seq_ctrl #(
    parameter int DW       = 128,
    parameter int IN_DEPTH = 32,
    parameter int WQ_DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic          cmd_sel,
    input  logic [9:0]    cmd_base,
    input  logic [9:0]    cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic [4:0]    in_addr,
    output logic          in_wen,
    output logic [DW-1:0] in_din,
    input  logic [DW-1:0] in_dout,
    output logic [9:0]    wq_addr,
    output logic          wq_wen,
    output logic [DW-1:0] wq_din,
    input  logic [DW-1:0] wq_dout,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [10:0] IN_MAX = 11'(IN_DEPTH - 1);
    localparam logic [10:0] WQ_MAX = 11'(WQ_DEPTH - 1);

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  rem_q, rem_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_last_q, rd_last_d;
    logic        err_q, err_d;

    logic [10:0] cmd_end;
    logic        cmd_oob;
    logic        wr_fire;

    assign cmd_end = {1'b0, cmd_base} + {1'b0, cmd_len};
    assign cmd_oob = cmd_end > (cmd_sel ? WQ_MAX : IN_MAX);
    assign wr_fire = (state_q == WRITE) && wr_valid;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_oob) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d   = cmd_sel;
                        cnt_d   = cmd_base;
                        rem_d   = cmd_len;
                        state_d = cmd_op ? READ : WRITE;
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    cnt_d = cnt_q + 10'd1;
                    if (rem_q == '0) state_d = DONE;
                    else             rem_d   = rem_q - 10'd1;
                end
            end
            READ: begin
                // Read data returns one cycle after issue, so valid/last are delayed flags.
                rd_valid_d = 1'b1;
                rd_last_d  = (rem_q == '0);
                cnt_d      = cnt_q + 10'd1;
                if (rem_q == '0) state_d = DRAIN;
                else             rem_d   = rem_q - 10'd1;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign wr_ready  = (state_q == WRITE);

    assign in_addr   = cnt_q[4:0];
    assign wq_addr   = cnt_q;
    assign in_din    = wr_data;
    assign wq_din    = wr_data;
    assign in_wen    = ~(wr_fire & ~sel_q);
    assign wq_wen    = ~(wr_fire & sel_q);

    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign rd_data   = sel_q ? wq_dout : in_dout;

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Bench for sram_seq_ctrl: behavioural SRAMs plus shadow memories that predict
// every write address/data, read word, and status pulse of random and directed bursts.
module tb_sram_seq_ctrl;

    localparam int DW       = 128;
    localparam int IN_DEPTH = 32;
    localparam int WQ_DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic          cmd_sel = 1'b0;
    logic [9:0]    cmd_base = '0;
    logic [9:0]    cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic [4:0]    in_addr;
    logic          in_wen;
    logic [DW-1:0] in_din;
    logic [DW-1:0] in_dout;
    logic [9:0]    wq_addr;
    logic          wq_wen;
    logic [DW-1:0] wq_din;
    logic [DW-1:0] wq_dout;
    logic          busy;
    logic          done;
    logic          err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [DW-1:0] in_mem  [IN_DEPTH];
    logic [DW-1:0] wq_mem  [WQ_DEPTH];
    logic [DW-1:0] ref_in  [IN_DEPTH];
    logic [DW-1:0] ref_wq  [WQ_DEPTH];

    always #5 clk = ~clk;

    sram_seq_ctrl #(
        .DW       (DW),
        .IN_DEPTH (IN_DEPTH),
        .WQ_DEPTH (WQ_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sel   (cmd_sel),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .in_addr   (in_addr),
        .in_wen    (in_wen),
        .in_din    (in_din),
        .in_dout   (in_dout),
        .wq_addr   (wq_addr),
        .wq_wen    (wq_wen),
        .wq_din    (wq_din),
        .wq_dout   (wq_dout),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Synchronous single-port SRAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (!in_wen) in_mem[in_addr] <= in_din;
        in_dout <= in_mem[in_addr];
        if (!wq_wen) wq_mem[wq_addr] <= wq_din;
        wq_dout <= wq_mem[wq_addr];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts and ends on a falling edge; the cycle after it returns is an IDLE cycle.
    task automatic run_cmd(input bit op, input bit sel, input int unsigned base,
                           input int unsigned len, input int unsigned gap_lo,
                           input int unsigned gap_hi);
        int unsigned   lim;
        int unsigned   a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_word;
        lim = sel ? WQ_DEPTH - 1 : IN_DEPTH - 1;

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_base  = 10'(base);
        cmd_len   = 10'(len);
        #1;
        check("accept_ready", cmd_ready, 1);
        check("accept_busy", busy, 0);
        check("accept_err", err, 0);
        check("accept_wen", {in_wen, wq_wen}, 2'b11);
        @(negedge clk);
        cmd_valid = 1'b0;

        if (base + len > lim) begin
            #1;
            check("rej_err", err, 1);
            check("rej_busy", busy, 0);
            check("rej_ready", cmd_ready, 1);
            check("rej_wen", {in_wen, wq_wen}, 2'b11);
            @(negedge clk);
            return;
        end

        if (!op) begin
            for (int unsigned i = 0; i <= len; i++) begin
                repeat ($urandom_range(gap_hi, gap_lo)) begin
                    wr_valid = 1'b0;
                    #1;
                    check("gap_ready", wr_ready, 1);
                    check("gap_wen", {in_wen, wq_wen}, 2'b11);
                    @(negedge clk);
                end
                d        = rand_word();
                a        = base + i;
                wr_valid = 1'b1;
                wr_data  = d;
                #1;
                check("wr_ready", wr_ready, 1);
                check("wr_busy", busy, 1);
                if (sel) begin
                    check("wr_wen", {in_wen, wq_wen}, 2'b10);
                    check("wr_addr", wq_addr, a);
                    check("wr_din", wq_din, d);
                    ref_wq[a] = d;
                end else begin
                    check("wr_wen", {in_wen, wq_wen}, 2'b01);
                    check("wr_addr", in_addr, a);
                    check("wr_din", in_din, d);
                    ref_in[a] = d;
                end
                @(negedge clk);
            end
            wr_valid = 1'b0;
        end else begin
            #1;
            check("rd_first_valid", rd_valid, 0);
            check("rd_first_addr", sel ? wq_addr : 10'(in_addr), base);
            check("rd_first_wen", {in_wen, wq_wen}, 2'b11);
            @(negedge clk);
            for (int unsigned i = 1; i <= len + 1; i++) begin
                a        = base + i - 1;
                exp_word = sel ? ref_wq[a] : ref_in[a];
                #1;
                check("rd_valid", rd_valid, 1);
                check("rd_last", rd_last, (i == len + 1) ? 1 : 0);
                check("rd_data", rd_data, exp_word);
                check("rd_wen", {in_wen, wq_wen}, 2'b11);
                if (i <= len) check("rd_addr", sel ? wq_addr : 10'(in_addr), base + i);
                @(negedge clk);
            end
        end

        #1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_rd_valid", {rd_valid, rd_last}, 2'b00);
        check("done_wen", {in_wen, wq_wen}, 2'b11);
        check("done_wr_ready", wr_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          op, sel;
        int unsigned base, len;

        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wen", {in_wen, wq_wen}, 2'b11);
        check("rst_rd", {rd_valid, rd_last}, 2'b00);
        check("rst_pulses", {done, err, wr_ready}, 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fill both memories so every later read has a known expected word.
        run_cmd(0, 0, 0, IN_DEPTH - 1, 0, 1);
        run_cmd(0, 1, 0, WQ_DEPTH - 1, 0, 1);

        run_cmd(0, 1, 1020, 3, 0, 0);
        run_cmd(1, 1, 1020, 3, 0, 0);
        run_cmd(0, 0, 30, 2, 0, 0);
        run_cmd(0, 0, 0, 0, 3, 3);
        run_cmd(1, 0, 0, 0, 0, 0);
        run_cmd(1, 1, 1021, 3, 0, 0);
        run_cmd(0, 0, 31, 0, 0, 2);
        run_cmd(1, 0, 31, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            op  = 1'($urandom_range(1, 0));
            sel = 1'($urandom_range(1, 0));
            if (sel) begin
                base = ($urandom_range(3, 0) == 0) ? $urandom_range(1023, 1000) : $urandom_range(1023, 0);
                len  = $urandom_range(15, 0);
            end else begin
                base = $urandom_range(40, 0);
                len  = $urandom_range(7, 0);
            end
            run_cmd(op, sel, base, len, 0, 2);
        end

        // Reset in the second READ cycle abandons the burst with no done pulse.
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_sel   = 1'b0;
        cmd_base  = '0;
        cmd_len   = 10'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst_valid", rd_valid, 1);
        rst = 1'b1;
        #1;
        check("async_rd", {rd_valid, rd_last}, 2'b00);
        check("async_wen", {in_wen, wq_wen}, 2'b11);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("post_rst_state", {done, busy, rd_valid, cmd_ready}, 4'b0001);
            @(negedge clk);
        end

        run_cmd(1, 0, 0, 7, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
